// File: rtl/joy_trackball_emu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : joy_trackball_emu_pkg
// Purpose  : Shared widths, axis state encoding and step helper for the
//            joystick-to-trackball emulator.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package joy_trackball_emu_pkg;

  localparam int VEL_W               = 4;
  localparam int PHASE_W             = 9;
  localparam int SPEED_W             = 2;
  localparam int ACCEL_TICKS_DEFAULT = 32;
  localparam int ACC_W               = $clog2(ACCEL_TICKS_DEFAULT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MOVE = 1'b1
  } axis_state_t;

  // Phase increment for one tick: velocity scaled by 2**speed. The result
  // carries one extra bit so the caller can add it to the phase and see the
  // wrap-around in the MSB.
  function automatic logic [PHASE_W:0] phase_step(
    input logic [VEL_W-1:0]   vel,
    input logic [SPEED_W-1:0] speed
  );
    logic [PHASE_W:0] v_ext;
    v_ext = {{(PHASE_W + 1 - VEL_W){1'b0}}, vel};
    return v_ext << speed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/joy_trackball_emu_axis.sv
`default_nettype none
// ============================================================================
// Module   : joy_axis
// Purpose  : One trackball axis. Turns a +1/-1/0 request into a direction
//            level and a clock that toggles each time the phase accumulator
//            wraps, with a velocity that ramps while the request is held.
// Ports    : clk_sys  in   system clock
//            reset    in   synchronous active-high reset
//            tick     in   one-cycle motion tick strobe
//            req_pos  in   request towards positive direction
//            req_neg  in   request towards negative direction
//            speed    in   step shift (0..3)
//            dir      out  registered direction, 1 = positive
//            qclk     out  registered motion clock
// Revision : 1.0 - initial release
// ============================================================================
module joy_axis
  import joy_trackball_emu_pkg::*;
#(
  parameter int ACCEL_TICKS = 32,
  parameter int VMAX        = 15
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               tick,
  input  logic               req_pos,
  input  logic               req_neg,
  input  logic [SPEED_W-1:0] speed,
  output logic               dir,
  output logic               qclk
);

  localparam int                  ACC_BITS = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [ACC_BITS-1:0] ACC_LAST = ACC_BITS'(ACCEL_TICKS - 1);
  localparam logic [VEL_W-1:0]    VEL_TOP  = VEL_W'(VMAX);

  axis_state_t         state;
  logic [VEL_W-1:0]    vel;
  logic [PHASE_W-1:0]  phase;
  logic [ACC_BITS-1:0] accel;

  logic                active;
  logic [PHASE_W:0]    sum;

  assign active = req_pos | req_neg;
  assign sum    = {1'b0, phase} + phase_step(vel, speed);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      vel   <= '0;
      phase <= '0;
      accel <= '0;
      dir   <= 1'b0;
      qclk  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (active) begin
            state <= MOVE;
            vel   <= VEL_W'(1);
            phase <= '0;
            accel <= '0;
            dir   <= req_pos;
          end
        end
        MOVE: begin
          if (!active) begin
            // dir and qclk keep their last levels while idle
            state <= IDLE;
            vel   <= '0;
            phase <= '0;
            accel <= '0;
          end else if (req_pos != dir) begin
            // Reversal restarts the ramp; the tick on this cycle is dropped
            vel   <= VEL_W'(1);
            phase <= '0;
            accel <= '0;
            dir   <= req_pos;
          end else if (tick) begin
            phase <= sum[PHASE_W-1:0];
            if (sum[PHASE_W]) begin
              qclk <= ~qclk;
            end
            if (accel == ACC_LAST) begin
              accel <= '0;
              if (vel < VEL_TOP) begin
                vel <= vel + 1'b1;
              end
            end else begin
              accel <= accel + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/joy_trackball_emu.sv
`default_nettype none
// ============================================================================
// Module   : joy_trackball_emu
// Purpose  : Joystick/D-pad to trackball emulator. Registers the pad inputs,
//            generates the motion tick and drives two axis engines whose
//            direction outputs are inverted by the cocktail flip.
// Ports    : clk_sys    in   system clock
//            reset      in   synchronous active-high reset
//            joy_up     in   up held
//            joy_down   in   down held
//            joy_left   in   left held
//            joy_right  in   right held
//            speed      in   step shift: 0=x1 .. 3=x8
//            flip       in   inverts both direction outputs
//            h_dir      out  horizontal direction (1 = right before flip)
//            h_clk      out  horizontal motion clock
//            v_dir      out  vertical direction (1 = up before flip)
//            v_clk      out  vertical motion clock
// Revision : 1.0 - initial release
// ============================================================================
module joy_trackball_emu
  import joy_trackball_emu_pkg::*;
#(
  parameter int TICK_DIV    = 12000,
  parameter int ACCEL_TICKS = 32,
  parameter int VMAX        = 15
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               joy_up,
  input  logic               joy_down,
  input  logic               joy_left,
  input  logic               joy_right,
  input  logic [SPEED_W-1:0] speed,
  input  logic               flip,
  output logic               h_dir,
  output logic               h_clk,
  output logic               v_dir,
  output logic               v_clk
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic             up_q;
  logic             down_q;
  logic             left_q;
  logic             right_q;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             dir_h;
  logic             dir_v;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      up_q    <= joy_up;
      down_q  <= joy_down;
      left_q  <= joy_left;
      right_q <= joy_right;
    end
  end

  // Free-running divider; joystick activity never resets it
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == CNT_LAST);

  // Opposing directions held together cancel to no request
  joy_axis #(
    .ACCEL_TICKS (ACCEL_TICKS),
    .VMAX        (VMAX)
  ) u_axis_h (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tick    (tick),
    .req_pos (right_q & ~left_q),
    .req_neg (left_q & ~right_q),
    .speed   (speed),
    .dir     (dir_h),
    .qclk    (h_clk)
  );

  joy_axis #(
    .ACCEL_TICKS (ACCEL_TICKS),
    .VMAX        (VMAX)
  ) u_axis_v (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tick    (tick),
    .req_pos (up_q & ~down_q),
    .req_neg (down_q & ~up_q),
    .speed   (speed),
    .dir     (dir_v),
    .qclk    (v_clk)
  );

  assign h_dir = dir_h ^ flip;
  assign v_dir = dir_v ^ flip;

endmodule
`default_nettype wire

// File: tb/tb_joy_trackball_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_joy_trackball_emu
// Purpose  : Self-checking bench for joy_trackball_emu (TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_joy_trackball_emu;

  localparam int TICK_DIV    = 4;
  localparam int ACCEL_TICKS = 32;
  localparam int VMAX        = 15;

  logic       clk_sys   = 1'b0;
  logic       reset     = 1'b1;
  logic       joy_up    = 1'b0;
  logic       joy_down  = 1'b0;
  logic       joy_left  = 1'b0;
  logic       joy_right = 1'b0;
  logic [1:0] speed     = 2'd0;
  logic       flip      = 1'b0;
  logic       h_dir, h_clk, v_dir, v_clk;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  joy_trackball_emu #(
    .TICK_DIV    (TICK_DIV),
    .ACCEL_TICKS (ACCEL_TICKS),
    .VMAX        (VMAX)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .joy_up    (joy_up),
    .joy_down  (joy_down),
    .joy_left  (joy_left),
    .joy_right (joy_right),
    .speed     (speed),
    .flip      (flip),
    .h_dir     (h_dir),
    .h_clk     (h_clk),
    .v_dir     (v_dir),
    .v_clk     (v_clk)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model: each axis is a motion segment. Position accumulates as a plain
  // integer; the clock level is the segment's starting level flipped once
  // per 512 units travelled.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic moving;
    logic dir;
    logic base;
    int   seg;
    int   total;
  } axm_t;

  function automatic logic m_clk(input axm_t a);
    return a.base ^ (((a.total / 512) % 2) != 0);
  endfunction

  function automatic axm_t m_axis(input axm_t a, input logic pos, input logic neg,
                                  input logic tk, input int spd);
    axm_t n;
    int   v;
    n = a;
    if (!a.moving) begin
      if (pos || neg) begin
        n.moving = 1'b1; n.dir = pos; n.base = m_clk(a); n.seg = 0; n.total = 0;
      end
    end else if (!pos && !neg) begin
      n.moving = 1'b0; n.base = m_clk(a); n.seg = 0; n.total = 0;
    end else if (pos != a.dir) begin
      n.dir = pos; n.base = m_clk(a); n.seg = 0; n.total = 0;
    end else if (tk) begin
      v = 1 + a.seg / ACCEL_TICKS;
      if (v > VMAX) v = VMAX;
      n.total = a.total + v * (1 << spd);
      n.seg   = a.seg + 1;
    end
    return n;
  endfunction

  axm_t mh = '0;
  axm_t mv = '0;
  logic m_up = 1'b0, m_dn = 1'b0, m_lf = 1'b0, m_rt = 1'b0;
  int   ecount = 0;
  int   cyc = 0;
  int   last_h = -1, last_v = -1;
  logic prev_h = 1'b0, prev_v = 1'b0;

  initial begin : compare
    logic tk;
    logic was_reset;
    forever begin
      @(posedge clk_sys);
      was_reset = reset;
      if (reset) begin
        mh = '0; mv = '0;
        m_up = 1'b0; m_dn = 1'b0; m_lf = 1'b0; m_rt = 1'b0;
        ecount = 0;
      end else begin
        tk = ((ecount % TICK_DIV) == TICK_DIV - 1);
        mh = m_axis(mh, m_rt & ~m_lf, m_lf & ~m_rt, tk, int'(speed));
        mv = m_axis(mv, m_up & ~m_dn, m_dn & ~m_up, tk, int'(speed));
        ecount++;
        m_up = joy_up; m_dn = joy_down; m_lf = joy_left; m_rt = joy_right;
      end
      cyc++;
      #1;
      chk("model_h_dir", h_dir, mh.dir ^ flip);
      chk("model_v_dir", v_dir, mv.dir ^ flip);
      chk("model_h_clk", h_clk, m_clk(mh));
      chk("model_v_clk", v_clk, m_clk(mv));
      if (was_reset) begin
        last_h = -1; last_v = -1;
      end else begin
        if (h_clk !== prev_h) begin
          if (last_h >= 0) chk_range("h_clk_min_gap", cyc - last_h, TICK_DIV, 1 << 30);
          last_h = cyc;
        end
        if (v_clk !== prev_v) begin
          if (last_v >= 0) chk_range("v_clk_min_gap", cyc - last_v, TICK_DIV, 1 << 30);
          last_v = cyc;
        end
      end
      prev_h = h_clk;
      prev_v = v_clk;
    end
  end

  // Called right after inputs change on a negedge. Checks h_dir after the
  // register edge (d0) and after the axis edge (d1), then counts posedges
  // until h_clk leaves the level it had after the register edge.
  task automatic measure_h(input logic d0, input logic d1, output int n);
    logic start;
    @(posedge clk_sys); #1;
    chk("h_dir_before_axis", h_dir, d0);
    start = h_clk;
    @(posedge clk_sys); #1;
    chk("h_dir_after_axis", h_dir, d1);
    n = 2;
    while (h_clk === start && n < 400) begin
      @(posedge clk_sys); #1;
      n++;
    end
  endtask

  task automatic idle_negedges(input int k);
    repeat (k) @(negedge clk_sys);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int   n;
    int   cnt;
    logic hc, hd, pv;

    // Test 1: reset, then quiet
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_h_dir", h_dir, 0);
    chk("reset_h_clk", h_clk, 0);
    chk("reset_v_dir", v_dir, 0);
    chk("reset_v_clk", v_clk, 0);
    @(negedge clk_sys);
    reset = 1'b0;
    cnt = 0;
    repeat (2000) begin
      @(posedge clk_sys); #1;
      if (h_dir || h_clk || v_dir || v_clk) cnt++;
    end
    chk("idle_outputs_nonzero_cycles", cnt, 0);

    // Test 2: right from idle at speed 3; first toggle on tick 48
    @(negedge clk_sys);
    speed = 2'd3;
    joy_right = 1'b1;
    measure_h(1'b0, 1'b1, n);
    chk_range("t2_first_h_toggle_edge", n, 191, 194);
    chk("t2_v_clk_quiet", v_clk, 0);
    @(negedge clk_sys);
    joy_right = 1'b0;
    idle_negedges(5);

    // Test 3: both horizontal directions cancel, then left alone moves
    joy_left = 1'b1;
    joy_right = 1'b1;
    hc = h_clk;
    hd = h_dir;
    cnt = 0;
    repeat (300) begin
      @(posedge clk_sys); #1;
      if (h_clk !== hc || h_dir !== hd) cnt++;
    end
    chk("t3_both_held_changes", cnt, 0);
    @(negedge clk_sys);
    joy_right = 1'b0;
    measure_h(1'b1, 1'b0, n);
    chk_range("t3_left_first_toggle_edge", n, 191, 194);
    @(negedge clk_sys);
    joy_left = 1'b0;
    idle_negedges(5);

    // Test 5: ~100 ticks of right, then reverse to left
    joy_right = 1'b1;
    idle_negedges(402);
    joy_right = 1'b0;
    joy_left = 1'b1;
    measure_h(1'b1, 1'b0, n);
    chk_range("t5_reversal_first_toggle_edge", n, 191, 194);
    @(negedge clk_sys);
    joy_left = 1'b0;
    idle_negedges(5);

    // Test 4: hold up for 1000 ticks: 93120 units -> 181 toggles
    joy_up = 1'b1;
    pv = v_clk;
    cnt = 0;
    repeat (4002) begin
      @(posedge clk_sys); #1;
      if (v_clk !== pv) cnt++;
      pv = v_clk;
    end
    chk("t4_v_toggles_1000_ticks", cnt, 181);
    chk("t4_v_dir_up", v_dir, 1);
    chk("t4_h_clk_quiet_level", h_clk, m_clk(mh));
    @(negedge clk_sys);
    joy_up = 1'b0;
    idle_negedges(5);

    // Test 6: flip while moving up, then reset mid-motion
    flip = 1'b1;
    joy_up = 1'b1;
    idle_negedges(3);
    chk("t6_v_dir_flipped", v_dir, 0);
    chk("t6_h_dir_flipped", h_dir, 1);
    idle_negedges(600);
    flip = 1'b0;
    #1;
    chk("t6_v_dir_unflipped_comb", v_dir, 1);
    idle_negedges(300);
    flip = 1'b1;
    #1;
    chk("t6_v_dir_reflipped_comb", v_dir, 0);
    idle_negedges(200);
    flip = 1'b0;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    chk("t6_reset_h_dir", h_dir, 0);
    chk("t6_reset_h_clk", h_clk, 0);
    chk("t6_reset_v_dir", v_dir, 0);
    chk("t6_reset_v_clk", v_clk, 0);
    @(negedge clk_sys);
    reset = 1'b0;
    joy_up = 1'b0;
    idle_negedges(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/joy_trackball_emu.md
Name: joy_trackball_emu

Overview:
- Converts digital joystick/D-pad directions into the quadrature-style direction and clock pulses the Centipede core expects on its trackball input.
- Lets pad-only players steer smoothly, with a velocity ramp.
- Sits upstream of the core, in parallel with the mouse-driven trackball path; the top level ORs or muxes the two on trakball_i.

Parameters:
- TICK_DIV, 12000, clk_sys cycles per motion tick (1 kHz at 12 MHz)
- ACCEL_TICKS, 32, ticks spent at each velocity step before incrementing
- VMAX, 15, maximum velocity (4-bit)

Ports:
- clk_sys  in  1  system clock (12 MHz)
- reset  in  1  synchronous, active-high reset
- joy_up  in  1  up held (active high)
- joy_down  in  1  down held
- joy_left  in  1  left held
- joy_right  in  1  right held
- speed  in  2  step shift: 0=x1, 1=x2, 2=x4, 3=x8
- flip  in  1  cocktail flip from core; inverts both dir outputs
- h_dir  out  1  horizontal direction, 1 = right (before flip)
- h_clk  out  1  horizontal clock; toggles once per motion count
- v_dir  out  1  vertical direction, 1 = up (before flip)
- v_clk  out  1  vertical clock; toggles once per motion count

Behaviour:
- Clock and reset: one clock (clk_sys); reset is synchronous and active-high.
- Reset values: all outputs 0; tick counter 0; per-axis vel, phase and accel counter 0; axis state IDLE.
- Input capture: joystick inputs registered once, 1-cycle latency; all decisions use the registered values.
- Tick generation:
  - Free-running counter 0..TICK_DIV-1; tick strobe is one cycle wide when the counter wraps.
  - The counter is not reset by joystick activity.
- Axis request per axis: +1 / -1 / 0.
  - H: right only = +1, left only = -1, neither or both = 0.
  - V: up only = +1, down only = -1, neither or both = 0.
- Axis FSM states (per axis, identical logic): IDLE, MOVE.
  - IDLE, request != 0 (any cycle): go to MOVE; vel=1, phase=0, accel=0; dir = (request==+1); clk unchanged.
  - MOVE, request == 0: go to IDLE; vel=0, phase=0; dir and clk hold their last values.
  - MOVE, request sign differs from dir (reversal): stay in MOVE; vel=1, phase=0, accel=0; dir updated in the same cycle; no clk toggle on that cycle even if it is a tick.
  - MOVE, tick, same direction:
    - sum = phase + (vel << speed), 10-bit; phase <= sum[8:0]; if sum[9], toggle clk.
    - accel increments; when accel == ACCEL_TICKS-1, accel <= 0 and vel <= min(vel+1, VMAX), effective from the next tick.
- Arithmetic rules:
  - phase is 9 bits.
  - Max step is 15<<3 = 120 < 512, so at most one toggle per tick; the minimum clk half-period is TICK_DIV cycles.
  - speed changes take effect on the next tick; no state is cleared.
- Outputs:
  - h_dir_out = dir_h ^ flip; v_dir_out = dir_v ^ flip. The XOR is combinational from registered dir.
  - clk outputs come straight from flops.
- Reset mid-motion: all state returns to reset values on the next edge; no partial toggle.

Decomposition:
- Shared package:
  - localparam widths: VEL_W=4, PHASE_W=9, ACC_W=$clog2(ACCEL_TICKS).
  - axis-state enum {IDLE, MOVE}.
- Sub-module joy_axis, instantiated twice (H, V). Ports: clk_sys, reset, tick, req_pos, req_neg, speed, dir, qclk.
- Top level holds the input registers, tick divider and flip XOR.

Test Plan:
Bench setting for all cases: TICK_DIV=4, ACCEL_TICKS=32.
1. Reset held 3 cycles, then released with no input -> all outputs stay 0 for 2000 cycles.
2. speed=3, hold right from idle:
   - h_dir=1 two cycles after the press.
   - Ticks 1-32 use vel 1 (step 8); phase reaches 256.
   - Ticks 33-64 use vel 2 (step 16); h_clk first toggles on tick 48.
   - v_clk never toggles.
3. Hold left and right together -> H axis stays IDLE, h_clk constant. Release right -> h_dir=0 and motion starts at vel 1.
4. Hold up at speed=3 for 1000 ticks:
   - vel saturates at 15 after tick 448.
   - Thereafter v_clk toggles on average every 512/120 ticks.
   - No two toggles occur within fewer than 4 cycles.
5. Reversal mid-motion: after 100 ticks of right, switch to left -> h_dir=0 the same cycle the registered request changes; no toggle on that tick; vel restarts at 1 (next toggle at tick 48 after reversal, speed=3).
6. flip=1 while holding up -> v_dir=0; toggle flip mid-motion -> v_dir follows combinationally and v_clk cadence is unaffected. Assert reset mid-motion -> all outputs 0 on the next edge.
